pc_gen_btb: RTL and testbench
=============================

Name: pc_gen_btb

Overview:
- Parametrised successor to the CPU's program counter.
- Generates the fetch PC with a ready/valid handshake toward the fetch/icache stage.
- Predicts next-PC through a direct-mapped BTB with 2-bit saturating counters, trained by the branch-resolution path.
- Accepts redirects (mispredict/flush); a redirect arriving while the block is disabled is held as pending.

Parameters:
- ADDR_W, `RAM_ADR_W, PC/address width.
- RESET_PC, 0, value loaded into pc_o at reset.
- BTB_DEPTH, 64, BTB entry count; power of two, at least 2.
- IDX_W, $clog2(BTB_DEPTH), BTB index width; derived, do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global enable; 0 freezes all state except pending-redirect capture and BTB update.
- fetch_ready_i  in  1  fetch stage accepts pc_o this cycle.
- revise_en_i  in  1  redirect request.
- rev_pc_i  in  ADDR_W  redirect target.
- upd_en_i  in  1  branch resolved; train BTB.
- upd_pc_i  in  ADDR_W  PC of resolved branch.
- upd_taken_i  in  1  resolved direction.
- upd_target_i  in  ADDR_W  resolved target.
- pc_o  out  ADDR_W  current fetch PC.
- pc_valid_o  out  1  pc_o is a valid fetch request.
- pred_taken_o  out  1  prediction attached to pc_o.
- pred_target_o  out  ADDR_W  predicted next PC for pc_o.

Behaviour:
- Reset (rst=0, async):
  - pc_o=RESET_PC, pc_valid_o=0.
  - All BTB valid bits cleared; counters set to 01.
  - Pending flag cleared; FSM=S_IDLE.
- Alignment: rev_pc_i[1:0] and upd_target_i[1:0] are forced to 0 before use.
- Sequential step: +4, wrapping modulo 2^ADDR_W.
- BTB index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2].
- Lookup (combinational on pc_o):
  - hit = valid && tag match.
  - pred_taken_o = hit && ctr[1].
  - pred_target_o = pred_taken_o ? entry target : pc_o+4.
- FSM:
  - S_IDLE: pc_valid_o=0. On en=1, go to S_RUN; pc_valid_o=1 next cycle with pc_o=RESET_PC. A redirect seen in S_IDLE with en=0 is captured as pending and the FSM goes to S_PEND.
  - S_RUN, en=1, revise_en_i=1: pc_o<=rev_pc_i next cycle. Redirect has priority over the handshake; the current request is dropped even if fetch_ready_i=1.
  - S_RUN, en=1, no redirect: if pc_valid_o && fetch_ready_i, pc_o<=pred_target_o; otherwise pc_o holds.
  - S_RUN, en=0: pc_o holds. A revise_en_i loads pend_pc and the FSM goes to S_PEND.
  - S_PEND: pc_valid_o=0. A newer redirect overwrites pend_pc. On the first cycle with en=1, pc_o<=pend_pc (or rev_pc_i if revise_en_i is also high that cycle), then S_RUN.
- BTB update (any FSM state, independent of en):
  - Tag hit: counter increments on taken, decrements on not-taken, saturating at 11/00. Target is written only when taken.
  - Miss and taken: allocate/overwrite with valid=1, new tag, new target, ctr=10.
  - Miss and not-taken: no change.
  - Update and lookup on the same entry in the same cycle: lookup returns the pre-update value; the write takes effect at the clock edge.
- Update and redirect in the same cycle: both take effect independently.
- Reset asserted mid-operation: immediate return to reset values. Pending redirect is lost; BTB contents are lost.

Optional Feature:
- Macro: PC_RVC_EN.
- Defined:
  - Adds input fetch_is_rvc_i (1 bit); sequential step is 2 when it is high, else 4.
  - Alignment clears bit 0 only.
  - Index = pc[IDX_W:1]; tag = pc[ADDR_W-1:IDX_W+1].
  - Fall-through pred_target_o uses the same step.
- Undefined: port absent; step fixed at 4; 4-byte alignment as above.

Decomposition:
- Shared header/package holds:
  - FSM state encodings S_IDLE/S_RUN/S_PEND.
  - 2-bit counter constants CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11.
  - Default RESET_PC.
- Sub-module pc_btb:
  - Contents: BTB storage array, combinational lookup, and update logic.
  - Parameters: ADDR_W, BTB_DEPTH.
  - The top level keeps the FSM, pending register and PC register.

Test Plan:
- Reset then en=1, fetch_ready_i=1 constant: pc_valid_o=0 during reset; afterwards pc_o sequence 0x0,0x4,0x8,0xC with pred_taken_o=0.
- fetch_ready_i=0 for 3 cycles at pc_o=0x8: pc_o holds 0x8 with pc_valid_o=1; on ready=1, next pc_o=0xC.
- revise_en_i=1 with rev_pc_i=0x103 while fetch_ready_i=1 at pc 0x20: next pc_o=0x100, not 0x24.
- BTB training and prediction:
  - Train upd_pc=0x10 taken, target 0x80, then fetch from 0x0: at pc_o=0x10, pred_taken_o=1 and pred_target_o=0x80; next pc_o=0x80.
  - One not-taken update (counter 10→01): next visit to 0x10 predicts 0x14.
- Aliasing: train 0x10 taken, then fetch 0x10+4*BTB_DEPTH (0x110 for depth 64): tag mismatch, pred_taken_o=0.
- Pending redirect and reset:
  - en=0, redirect 0x200 then 0x300: pc_valid_o=0; on en=1, pc_o=0x300.
  - rst=0 mid-run: pc_o=RESET_PC asynchronously, BTB prediction cleared.

Source files
------------

// File: rtl/pc_gen_btb_pkg.sv
// Shared types and constants for the fetch PC generator and its BTB.
// PC_RVC_EN selects 2-byte (compressed) PC granularity instead of 4-byte.
`ifndef RAM_ADR_W
`define RAM_ADR_W 32
`endif

package pc_gen_btb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_t;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam int unsigned DEF_RESET_PC = 0;

`ifdef PC_RVC_EN
  localparam int PC_LSB = 1;
`else
  localparam int PC_LSB = 2;
`endif

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped BTB: combinational lookup on lk_pc, 2-bit counter training.
// Ports: lk_pc/step in, pred_taken/pred_target out, upd_* training in.
module pc_btb
  import pc_gen_btb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int BTB_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lk_pc,
  input  logic [ADDR_W-1:0] step,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_en,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W - PC_LSB;

  logic [BTB_DEPTH-1:0] vld;
  logic [1:0]           ctr   [BTB_DEPTH];
  logic [TAG_W-1:0]     tag_q [BTB_DEPTH];
  logic [ADDR_W-1:0]    tgt_q [BTB_DEPTH];

  logic [IDX_W-1:0] lidx;
  logic [TAG_W-1:0] ltag;
  logic [IDX_W-1:0] uidx;
  logic [TAG_W-1:0] utag;
  logic             lhit;
  logic             uhit;
  logic [1:0]       ctr_n;
  logic             unused_lsb;

  assign lidx = lk_pc[IDX_W+PC_LSB-1:PC_LSB];
  assign ltag = lk_pc[ADDR_W-1:IDX_W+PC_LSB];
  assign uidx = upd_pc[IDX_W+PC_LSB-1:PC_LSB];
  assign utag = upd_pc[ADDR_W-1:IDX_W+PC_LSB];
  assign unused_lsb = ^upd_pc[PC_LSB-1:0];

  assign lhit = vld[lidx] && (tag_q[lidx] == ltag);
  assign uhit = vld[uidx] && (tag_q[uidx] == utag);

  assign pred_taken  = lhit && ctr[lidx][1];
  assign pred_target = pred_taken ? tgt_q[lidx] : lk_pc + step;

  always_comb begin
    ctr_n = ctr[uidx];
    if (upd_taken && ctr[uidx] != CTR_ST)
      ctr_n = ctr[uidx] + 2'd1;
    else if (!upd_taken && ctr[uidx] != CTR_SNT)
      ctr_n = ctr[uidx] - 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        ctr[i]   <= CTR_WNT;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else if (upd_en) begin
      if (uhit) begin
        ctr[uidx] <= ctr_n;
        if (upd_taken)
          tgt_q[uidx] <= upd_target;
      end else if (upd_taken) begin
        vld[uidx]   <= 1'b1;
        tag_q[uidx] <= utag;
        tgt_q[uidx] <= upd_target;
        ctr[uidx]   <= CTR_WT;
      end
    end
  end

endmodule

// File: rtl/pc_gen_btb.sv
// Fetch PC generator: IDLE/RUN/PEND FSM, pending redirect, BTB prediction.
// Ports: en, fetch handshake, revise/upd inputs, pc_o + prediction out.
// PC_RVC_EN adds fetch_is_rvc_i (2-byte step when high).
module pc_gen_btb
  import pc_gen_btb_pkg::*;
#(
  parameter int              ADDR_W    = `RAM_ADR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEF_RESET_PC),
  parameter int              BTB_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fetch_ready_i,
`ifdef PC_RVC_EN
  input  logic              fetch_is_rvc_i,
`endif
  input  logic              revise_en_i,
  input  logic [ADDR_W-1:0] rev_pc_i,
  input  logic              upd_en_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_valid_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o
);

  localparam logic [ADDR_W-1:0] ALIGN =
    ~(ADDR_W'((1 << PC_LSB) - 1));

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc_q, pc_n;
  logic [ADDR_W-1:0] pend_q, pend_n;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] rev_pc;
  logic [ADDR_W-1:0] upd_tgt;

`ifdef PC_RVC_EN
  assign step = fetch_is_rvc_i ? ADDR_W'(2) : ADDR_W'(4);
`else
  assign step = ADDR_W'(4);
`endif

  assign rev_pc  = rev_pc_i & ALIGN;
  assign upd_tgt = upd_target_i & ALIGN;

  assign pc_o       = pc_q;
  assign pc_valid_o = (state == S_RUN);

  pc_btb #(
    .ADDR_W    (ADDR_W),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .lk_pc       (pc_q),
    .step        (step),
    .pred_taken  (pred_taken_o),
    .pred_target (pred_target_o),
    .upd_en      (upd_en_i),
    .upd_pc      (upd_pc_i),
    .upd_taken   (upd_taken_i),
    .upd_target  (upd_tgt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      pc_q   <= RESET_PC;
      pend_q <= '0;
    end else begin
      state  <= state_n;
      pc_q   <= pc_n;
      pend_q <= pend_n;
    end
  end

  // Redirect wins over the handshake; en=0 parks redirects in pend_q.
  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    pend_n  = pend_q;
    unique case (state)
      S_IDLE: begin
        if (en) begin
          state_n = S_RUN;
          if (revise_en_i)
            pc_n = rev_pc;
        end else if (revise_en_i) begin
          pend_n  = rev_pc;
          state_n = S_PEND;
        end
      end
      S_RUN: begin
        if (en) begin
          if (revise_en_i)
            pc_n = rev_pc;
          else if (fetch_ready_i)
            pc_n = pred_target_o;
        end else if (revise_en_i) begin
          pend_n  = rev_pc;
          state_n = S_PEND;
        end
      end
      S_PEND: begin
        if (en) begin
          pc_n    = revise_en_i ? rev_pc : pend_q;
          state_n = S_RUN;
        end else if (revise_en_i) begin
          pend_n = rev_pc;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_gen_btb.sv
// Directed bench for pc_gen_btb (ADDR_W=32, BTB_DEPTH=64).
// Inputs change and outputs are sampled at the falling edge.
module tb_pc_gen_btb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        fetch_ready_i = 1'b0;
  logic        revise_en_i = 1'b0;
  logic [31:0] rev_pc_i = '0;
  logic        upd_en_i = 1'b0;
  logic [31:0] upd_pc_i = '0;
  logic        upd_taken_i = 1'b0;
  logic [31:0] upd_target_i = '0;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_gen_btb #(
    .ADDR_W    (32),
    .RESET_PC  (32'h0),
    .BTB_DEPTH (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .fetch_ready_i (fetch_ready_i),
`ifdef PC_RVC_EN
    .fetch_is_rvc_i(1'b0),
`endif
    .revise_en_i   (revise_en_i),
    .rev_pc_i      (rev_pc_i),
    .upd_en_i      (upd_en_i),
    .upd_pc_i      (upd_pc_i),
    .upd_taken_i   (upd_taken_i),
    .upd_target_i  (upd_target_i),
    .pc_o          (pc_o),
    .pc_valid_o    (pc_valid_o),
    .pred_taken_o  (pred_taken_o),
    .pred_target_o (pred_target_o)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic redir(input logic [31:0] a);
    revise_en_i = 1'b1;
    rev_pc_i    = a;
  endtask

  task automatic train(input logic [31:0] p, input logic t,
                       input logic [31:0] tgt);
    upd_en_i     = 1'b1;
    upd_pc_i     = p;
    upd_taken_i  = t;
    upd_target_i = tgt;
  endtask

  task automatic quiet();
    revise_en_i = 1'b0;
    upd_en_i    = 1'b0;
  endtask

  initial begin
    tick();
    check("rst_valid", 32'(pc_valid_o), 32'd0);
    check("rst_pc", pc_o, 32'h0);
    tick();
    check("rst_valid2", 32'(pc_valid_o), 32'd0);
    rst = 1'b1;
    tick();
    check("idle_valid", 32'(pc_valid_o), 32'd0);
    en = 1'b1;
    fetch_ready_i = 1'b1;
    tick();
    check("seq0_valid", 32'(pc_valid_o), 32'd1);
    check("seq0_pc", pc_o, 32'h0);
    check("seq0_pt", 32'(pred_taken_o), 32'd0);
    tick();
    check("seq4_pc", pc_o, 32'h4);
    tick();
    check("seq8_pc", pc_o, 32'h8);
    fetch_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", pc_o, 32'h8);
      check("stall_valid", 32'(pc_valid_o), 32'd1);
    end
    fetch_ready_i = 1'b1;
    tick();
    check("seqC_pc", pc_o, 32'hC);
    check("seqC_pt", 32'(pred_taken_o), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("pc20", pc_o, 32'h20);
    redir(32'h103);
    tick();
    check("redir_pc", pc_o, 32'h100);
    quiet();
    train(32'h10, 1'b1, 32'h80);
    tick();
    check("after_redir_pc", pc_o, 32'h104);
    quiet();
    redir(32'h0);
    tick();
    quiet();
    check("restart_pc", pc_o, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    check("hit_pc", pc_o, 32'h10);
    check("hit_pt", 32'(pred_taken_o), 32'd1);
    check("hit_tgt", pred_target_o, 32'h80);
    tick();
    check("jump_pc", pc_o, 32'h80);
    check("jump_pt", 32'(pred_taken_o), 32'd0);
    check("jump_tgt", pred_target_o, 32'h84);
    train(32'h10, 1'b0, 32'h0);
    redir(32'hC);
    tick();
    quiet();
    check("nt_pc", pc_o, 32'hC);
    tick();
    check("nt_at10", pc_o, 32'h10);
    check("nt_pt", 32'(pred_taken_o), 32'd0);
    check("nt_tgt", pred_target_o, 32'h14);
    tick();
    check("nt_fall", pc_o, 32'h14);
    train(32'h10, 1'b1, 32'h80);
    redir(32'h110);
    tick();
    quiet();
    check("alias_pc", pc_o, 32'h110);
    check("alias_pt", 32'(pred_taken_o), 32'd0);
    check("alias_tgt", pred_target_o, 32'h114);
    redir(32'h10);
    tick();
    quiet();
    check("retrain_pt", 32'(pred_taken_o), 32'd1);
    check("retrain_tgt", pred_target_o, 32'h80);
    en = 1'b0;
    redir(32'h200);
    tick();
    check("pend_valid", 32'(pc_valid_o), 32'd0);
    redir(32'h300);
    tick();
    check("pend_valid2", 32'(pc_valid_o), 32'd0);
    quiet();
    en = 1'b1;
    tick();
    check("pend_pc", pc_o, 32'h300);
    check("pend_run", 32'(pc_valid_o), 32'd1);
    tick();
    check("pend_next", pc_o, 32'h304);
    #2 rst = 1'b0;
    #1;
    check("arst_pc", pc_o, 32'h0);
    check("arst_valid", 32'(pc_valid_o), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_pc", pc_o, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    check("post_rst_at10", pc_o, 32'h10);
    check("post_rst_pt", 32'(pred_taken_o), 32'd0);
    check("post_rst_tgt", pred_target_o, 32'h14);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
